// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - AD9235 conversion clock, warm-up, rate-divided capture and averaging
// Results leave over a valid/ready handshake; a result arriving while one is still pending is dropped.
module adc_sample_sequencer #(
    parameter int DIV_HALF      = 3,
    parameter int PIPE_LAT      = 7,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int AVG_LOG2      = 2
) (
    input  logic        clk,
    input  logic        nCR,
    input  logic        start,
    input  logic        stop,
    input  logic [11:0] code,
    output logic        adc_clk,
    output logic        busy,
    output logic [11:0] data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        overrun
);

    localparam int DW   = $clog2(DIV_HALF + 1);
    localparam int EMAX = (PIPE_LAT > SAMPLE_PERIOD) ? PIPE_LAT : SAMPLE_PERIOD;
    localparam int EW   = $clog2(EMAX + 1);
    localparam int CW   = AVG_LOG2 + 1;
    localparam int AW   = 12 + AVG_LOG2;
    localparam int NAVG = 1 << AVG_LOG2;

    typedef enum logic [1:0] {IDLE, WARMUP, WAIT, RESULT} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic            adc_clk_q, adc_clk_d;
    logic [EW-1:0]   edge_q, edge_d;
    logic [CW-1:0]   cap_q, cap_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [11:0]     data_q, data_d;
    logic            valid_q, valid_d;
    logic            ovr_q, ovr_d;
    logic            div_last, rise_tick, accept, run_start;
    logic [11:0]     result;

    // Free-running divider; rise_tick marks the clk edge where adc_clk goes high.
    always_comb begin
        div_last  = (div_q == DW'(DIV_HALF - 1));
        div_d     = div_last ? '0 : div_q + 1'b1;
        adc_clk_d = adc_clk_q ^ div_last;
        rise_tick = div_last & ~adc_clk_q;
    end

    assign run_start = (state_q == IDLE) && start && !stop;
    assign result    = acc_q[AVG_LOG2 +: 12];
    assign accept    = valid_q & data_ready;

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        cap_d   = cap_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (run_start) begin
                    state_d = WARMUP;
                    edge_d  = '0;
                    cap_d   = '0;
                    acc_d   = '0;
                end
            end
            WARMUP: begin
                if (rise_tick) begin
                    if (edge_q == EW'(PIPE_LAT - 1)) begin
                        state_d = WAIT;
                        edge_d  = '0;
                    end else begin
                        edge_d = edge_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (rise_tick) begin
                    if (edge_q == EW'(SAMPLE_PERIOD - 1)) begin
                        edge_d = '0;
                        acc_d  = acc_q + AW'(code);
                        cap_d  = cap_q + 1'b1;
                        if (cap_q == CW'(NAVG - 1)) state_d = RESULT;
                    end else begin
                        edge_d = edge_q + 1'b1;
                    end
                end
            end
            RESULT: begin
                state_d = WAIT;
                acc_d   = '0;
                cap_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            edge_d  = '0;
            cap_d   = '0;
            acc_d   = '0;
        end
    end

    // Output register is independent of stop so a pending result survives an abort.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (state_q == RESULT) begin
            if (!valid_q || accept) begin
                data_d  = result;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
        if (run_start) ovr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge nCR) begin
        if (!nCR) begin
            state_q   <= IDLE;
            div_q     <= '0;
            adc_clk_q <= 1'b0;
            edge_q    <= '0;
            cap_q     <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            adc_clk_q <= adc_clk_d;
            edge_q    <= edge_d;
            cap_q     <= cap_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign adc_clk    = adc_clk_q;
    assign busy       = (state_q != IDLE);
    assign data       = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb/tb_adc_sample_sequencer.sv - directed and random checks of adc_sample_sequencer against a tick-count model
module tb_adc_sample_sequencer;

    localparam int DH   = 3;
    localparam int PL   = 7;
    localparam int SP   = 4;
    localparam int AL   = 2;
    localparam int NAVG = 1 << AL;

    logic        clk = 1'b0;
    logic        nCR, start, stop, data_ready;
    logic [11:0] code;
    logic        adc_clk, busy, data_valid, overrun;
    logic [11:0] data;

    always #5 clk = ~clk;

    adc_sample_sequencer #(
        .DIV_HALF(DH), .PIPE_LAT(PL), .SAMPLE_PERIOD(SP), .AVG_LOG2(AL)
    ) dut (
        .clk(clk), .nCR(nCR), .start(start), .stop(stop), .code(code),
        .adc_clk(adc_clk), .busy(busy), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .overrun(overrun)
    );

    int checks = 0;
    int errors = 0;

    // Model: clk edges since reset release, rise ticks since start, captured codes, output register.
    int cyc;
    bit m_run;
    int m_ticks;
    int m_caps[$];
    int m_due;
    int m_res;
    bit m_dv;
    int m_data;
    bit m_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        cyc = 0; m_run = 0; m_ticks = 0; m_caps.delete();
        m_due = -1; m_res = 0; m_dv = 0; m_data = 0; m_ovr = 0;
    endfunction

    function automatic void model_edge();
        bit is_tick;
        int sum;
        is_tick = (cyc % (2 * DH)) == DH;
        if (m_due == cyc) begin
            if (!m_dv || data_ready) begin
                m_data = m_res;
                m_dv   = 1;
            end else begin
                m_ovr = 1;
            end
            m_due = -1;
        end else if (m_dv && data_ready) begin
            m_dv = 0;
        end
        if (m_run) begin
            if (stop) begin
                m_run = 0;
                m_caps.delete();
            end else if (is_tick) begin
                m_ticks++;
                if (m_ticks > PL && (m_ticks - PL) % SP == 0) begin
                    m_caps.push_back(int'(code));
                    if (m_caps.size() == NAVG) begin
                        sum = 0;
                        foreach (m_caps[i]) sum += m_caps[i];
                        m_res = sum / NAVG;
                        m_due = cyc + 1;
                        m_caps.delete();
                    end
                end
            end
        end else if (start && !stop) begin
            m_run = 1;
            m_ticks = 0;
            m_ovr = 0;
            m_caps.delete();
        end
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("adc_clk", adc_clk, ((cyc / DH) % 2) == 1);
        chk("busy", busy, m_run);
        chk("data_valid", data_valid, m_dv);
        chk("data", data, m_data);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nCR = 1'b0;
        #1;
        model_clear();
        chk("rst_adc_clk", adc_clk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        nCR = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    // Steps until data_valid rises; codes follow base+index-of-capture when base>=0, else hold.
    task automatic wait_valid(input string tag, input int base);
        int n;
        n = 0;
        while (!data_valid && n < 400) begin
            step();
            if (base >= 0) code = 12'(base + m_caps.size());
            n++;
        end
        chk(tag, data_valid, 1);
    endtask

    initial begin
        int s, t1, exp_cyc;
        logic [11:0] held;
        nCR = 1'b0; start = 1'b0; stop = 1'b0; code = '0; data_ready = 1'b1;
        model_clear();
        do_reset();

        // Idle after reset: divider runs, nothing else moves.
        for (int i = 0; i < 24; i++) step();

        // Averaging of 0x100..0x103 and first-result latency.
        code = 12'h100;
        pulse_start();
        s = cyc;
        t1 = s + 1;
        while (t1 % (2 * DH) != DH) t1++;
        exp_cyc = t1 + 2 * DH * (PL + NAVG * SP - 1) + 1;
        wait_valid("t2_valid_timeout", 12'h100);
        chk("t2_data", data, 12'h101);
        chk("t2_latency", cyc, exp_cyc);
        step();
        chk("t2_valid_one_clk", data_valid, 0);

        // Full-scale and zero codes.
        code = 12'hFFF;
        wait_valid("t3_valid_timeout_fff", -1);
        chk("t3_data_fff", data, 12'hFFF);
        code = 12'h000;
        step();
        wait_valid("t3_valid_timeout_zero", -1);
        chk("t3_data_zero", data, 12'h000);
        step();

        // Back-pressure: second result dropped, overrun sticky until next accepted start.
        data_ready = 1'b0;
        code = 12'h3A5;
        wait_valid("t4_valid_timeout", -1);
        held = data;
        code = 12'h5A3;
        for (int i = 0; i < 400 && !overrun; i++) step();
        chk("t4_overrun", overrun, 1);
        chk("t4_data_held", data, held);
        chk("t4_valid_held", data_valid, 1);
        pulse_stop();
        chk("t4_stop_busy", busy, 0);
        chk("t4_overrun_after_stop", overrun, 1);
        pulse_start();
        chk("t4_overrun_cleared", overrun, 0);
        data_ready = 1'b1;
        step();
        chk("t4_drain", data_valid, 0);

        // Abort after two captures, restart gives a clean average.
        pulse_stop();
        pulse_start();
        for (int i = 0; i < 400 && m_caps.size() < 2; i++) begin
            code = 12'($urandom);
            step();
        end
        pulse_stop();
        chk("t5_stop_busy", busy, 0);
        code = 12'h200;
        pulse_start();
        wait_valid("t5_valid_timeout", 12'h200);
        chk("t5_data", data, 12'h201);

        // Reset mid-run, then simultaneous start/stop in IDLE.
        for (int i = 0; i < 30; i++) step();
        do_reset();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("t6_busy_start_stop", busy, 0);
        for (int i = 0; i < 8; i++) step();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            code       = 12'($urandom);
            data_ready = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 149) == 0);
            stop       = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
